mext_ctrl: RTL and testbench
============================

MEXT_CTRL -- requirements
Module: mext_ctrl

Interface
REQ-001 Parameter BYPASS_SPECIAL, default 1: when 1, divide-by-zero and signed-overflow divides are resolved locally without launching the multiply/divide core.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req_valid  input  1  M-extension instruction present in execute; held stable by the pipeline while stall=1.
REQ-005 funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 rs1, rs2  input  32 each  operands.
REQ-007 kill  input  1  pipeline flush; discards the current operation.
REQ-008 stall  output  1  freezes the upstream pipeline.
REQ-009 res_valid  output  1  one-cycle pulse; res holds the final result.
REQ-010 res  output  32  result (registered).
REQ-011 md_valid, md_mode  output  1 each  launch pulse and mode to the core: 0 multiply, 1 divide.
REQ-012 md_a, md_b  output  32 each  unsigned magnitudes to the core.
REQ-013 md_ready  input  1  core completion pulse.
REQ-014 md_out  input  64  core result: product, or {remainder, quotient}.

Function
REQ-015 The FSM SHALL have the states IDLE, BUSY, DRAIN and DONE.
REQ-016 IDLE & req_valid & !kill SHALL go to BUSY with md_valid=1 for exactly that cycle, or go directly to DONE when a special case is bypassed.
REQ-017 BUSY SHALL go to DONE on md_ready, go to DRAIN on kill, and otherwise stay in BUSY.
REQ-018 DRAIN SHALL wait for md_ready, discard md_out, and return to IDLE with no res_valid.
REQ-019 DONE SHALL assert res_valid for one cycle and then go to IDLE.
REQ-020 Stall rules:
- stall = (IDLE & req_valid & !kill) | BUSY | DRAIN.
- stall SHALL be 0 in DONE.
- A req_valid seen in IDLE after DONE SHALL be treated as a new instruction.
REQ-021 Operand signedness:
- rs1 is signed for MULH, MULHSU, DIV, REM.
- rs2 is signed for MULH, DIV, REM.
- md_a and md_b SHALL be the absolute values of signed operands, captured at launch.
REQ-022 Multiply result sign = sign(rs1)^sign(rs2) over signed operands only; the 64-bit product SHALL be two's-complement negated when the sign is negative.
- MUL SHALL return bits [31:0].
- MULH, MULHSU, MULHU SHALL return bits [63:32].
REQ-023 Divide result signs:
- Quotient sign = sign(rs1)^sign(rs2).
- Remainder sign = sign(rs1).
- DIV/DIVU SHALL return md_out[31:0]; REM/REMU SHALL return md_out[63:32], each sign-corrected.
REQ-024 rs2==0: quotient SHALL be 0xFFFFFFFF and remainder SHALL be rs1, for both signed and unsigned ops.
REQ-025 DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient SHALL be 0x80000000 and remainder SHALL be 0.
REQ-026 Latency:
- Core path: res_valid SHALL occur one cycle after md_ready, i.e. 34 cycles after acceptance with the 32-iteration core.
- Bypass path: res_valid SHALL occur one cycle after acceptance.
REQ-027 With BYPASS_SPECIAL=0, special cases SHALL launch the core and REQ-024/025 values SHALL still be produced by post-correction.
REQ-028 kill in DONE SHALL suppress res_valid; kill in IDLE SHALL block acceptance.

Reset
REQ-029 rst_n low SHALL force:
- state IDLE.
- stall, res_valid, md_valid = 0.
- res, md_a, md_b, md_mode = 0.
- All captured sign and op fields = 0.
REQ-030 Reset mid-BUSY SHALL abandon the operation; a core ready pulse arriving after reset SHALL be ignored while in IDLE.

Structure
REQ-031 The funct3 encodings, FSM state encodings and the constants 0x80000000/0xFFFFFFFF SHALL live in the shared package mext_pkg.
REQ-032 The sign pre- and post-correction SHALL be a single combinational sub-module, mext_signfix; mext_ctrl SHALL hold the FSM and registers.

Verification
REQ-033 MUL rs1=7, rs2=0xFFFFFFFD -> res 0xFFFFFFEB; stall held 34 cycles; one md_valid pulse with md_a=7, md_b=3.
REQ-034 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each res_valid one cycle after acceptance with no md_valid.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -7 (0xFFFFFFF9) by 2 -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD.
REQ-037 kill 10 cycles after launch -> state DRAIN, no res_valid, stall released only after md_ready; the next request completes correctly.
REQ-038 rst_n low mid-BUSY -> all outputs 0 immediately; a late md_ready produces no res_valid.

Source files
------------

// File: rtl/mext_pkg.sv
// Shared encodings, constants and helpers for the RV32M execute-stage controller.
package mext_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // Attributes latched at launch and consumed when the core result returns.
  typedef struct packed {
    op_e  op;
    logic neg_lo;    // product / quotient sign
    logic neg_hi;    // remainder sign (follows the dividend)
    logic div_zero;
    logic div_ovf;
  } op_info_t;

  // MUL only needs the low word, which is identical for any operand signedness;
  // treating it as signed keeps the magnitudes handed to the core small.
  function automatic logic rs1_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic rs2_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mext_if.sv
// Handshake between the M-extension controller (master) and the multiply/divide core (slave).
interface mext_if;
  logic        md_valid;
  logic        md_mode;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_ready;
  logic [63:0] md_out;

  modport master (
    output md_valid, md_mode, md_a, md_b,
    input  md_ready, md_out
  );

  modport slave (
    input  md_valid, md_mode, md_a, md_b,
    output md_ready, md_out
  );
endinterface

// File: rtl/mext_signfix.sv
// Combinational sign handling: operand magnitudes and special-case detection before
// launch, and sign/special correction of the unsigned core result afterwards.
module mext_signfix
  import mext_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] pre_a,
  output logic [31:0] pre_b,
  output logic        pre_mode,
  output op_info_t    pre_info,
  output logic        special,
  output logic [31:0] special_res,
  input  op_info_t    cap_info,
  input  logic [31:0] cap_a,
  input  logic [63:0] md_out,
  output logic [31:0] post_res
);

  logic neg1, neg2, is_div, is_rem, div_zero, div_ovf;

  always_comb begin
    // NOTE: every output is assigned before any branch so no path can leave one
    // unassigned, which would otherwise infer a latch.
    neg1        = rs1_signed(op) & rs1[31];
    neg2        = rs2_signed(op) & rs2[31];
    is_div      = op[2];
    is_rem      = (op == OP_REM) || (op == OP_REMU);
    div_zero    = is_div && (rs2 == '0);
    div_ovf     = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == INT_MIN) && (rs2 == ALL_ONES);

    pre_a       = neg1 ? -rs1 : rs1;
    pre_b       = neg2 ? -rs2 : rs2;
    pre_mode    = is_div ? MODE_DIV : MODE_MUL;
    pre_info    = '{op: op, neg_lo: neg1 ^ neg2, neg_hi: neg1,
                    div_zero: div_zero, div_ovf: div_ovf};
    special     = div_zero || div_ovf;

    special_res = div_zero ? ALL_ONES : INT_MIN;
    if (is_rem) special_res = div_zero ? rs1 : '0;
  end

  logic [63:0] prod;
  logic [31:0] quo, rem;

  always_comb begin
    prod = cap_info.neg_lo ? -md_out : md_out;
    quo  = cap_info.neg_lo ? -md_out[31:0] : md_out[31:0];
    rem  = cap_info.neg_hi ? -md_out[63:32] : md_out[63:32];

    // The core's answer for a zero divisor is not trusted; |rs1| re-signed gives rs1 back.
    if (cap_info.div_zero) begin
      quo = ALL_ONES;
      rem = cap_info.neg_hi ? -cap_a : cap_a;
    end else if (cap_info.div_ovf) begin
      quo = INT_MIN;
      rem = '0;
    end

    unique case (cap_info.op)
      OP_MUL:                       post_res = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: post_res = prod[63:32];
      OP_DIV, OP_DIVU:              post_res = quo;
      default:                      post_res = rem;
    endcase
  end

endmodule

// File: rtl/mext_ctrl.sv
// RV32M execute-stage controller: accepts an instruction, launches the shared
// multiply/divide core (or resolves special divides locally) and returns the result.
module mext_ctrl
  import mext_pkg::*;
#(
  parameter bit BYPASS_SPECIAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        kill,
  output logic        stall,
  output logic        res_valid,
  output logic [31:0] res,
  mext_if.master      md
);

  state_e      state, state_nxt;
  op_info_t    cap_info, pre_info;
  logic [31:0] pre_a, pre_b, special_res, post_res;
  logic        pre_mode, special, accept, bypass;

  mext_signfix u_signfix (
    .op          (op_e'(funct3)),
    .rs1         (rs1),
    .rs2         (rs2),
    .pre_a       (pre_a),
    .pre_b       (pre_b),
    .pre_mode    (pre_mode),
    .pre_info    (pre_info),
    .special     (special),
    .special_res (special_res),
    .cap_info    (cap_info),
    .cap_a       (md.md_a),
    .md_out      (md.md_out),
    .post_res    (post_res)
  );

  always_comb begin
    accept    = (state == ST_IDLE) && req_valid && !kill;
    bypass    = BYPASS_SPECIAL && special;
    state_nxt = state;
    res_valid = 1'b0;

    unique case (state)
      ST_IDLE:  if (accept) state_nxt = bypass ? ST_DONE : ST_BUSY;
      // A kill coinciding with completion has nothing left to drain.
      ST_BUSY:  if (kill)             state_nxt = md.md_ready ? ST_IDLE : ST_DRAIN;
                else if (md.md_ready) state_nxt = ST_DONE;
      ST_DRAIN: if (md.md_ready) state_nxt = ST_IDLE;
      ST_DONE:  begin
                  state_nxt = ST_IDLE;
                  res_valid = !kill;
                end
      default:  state_nxt = ST_IDLE;
    endcase

    // Held low during reset even if the pipeline keeps req_valid asserted.
    stall = rst_n && (accept || (state == ST_BUSY) || (state == ST_DRAIN));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the datapath registers are reset as well, so no stale operand, mode or
  // result is ever visible on the outputs after a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md.md_valid <= 1'b0;
      md.md_mode  <= 1'b0;
      md.md_a     <= '0;
      md.md_b     <= '0;
      cap_info    <= '0;
      res         <= '0;
    end else begin
      md.md_valid <= accept && !bypass;
      if (accept && !bypass) begin
        md.md_mode <= pre_mode;
        md.md_a    <= pre_a;
        md.md_b    <= pre_b;
        cap_info   <= pre_info;
      end
      if (accept && bypass)
        res <= special_res;
      else if ((state == ST_BUSY) && md.md_ready && !kill)
        res <= post_res;
    end
  end

endmodule

// File: tb/tb_mext_ctrl.sv
// Self-checking bench for mext_ctrl with a behavioural 32-iteration multiply/divide core.
module tb_mext_ctrl;
  import mext_pkg::*;

  localparam int CORE_WAIT = 31;   // posedges between sampling md_valid and raising md_ready
  localparam int LAT_CORE  = 34;
  localparam int LAT_BYP   = 1;
  localparam int BUDGET    = 200;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, kill, stall, res_valid;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, res;
  int          n_checks = 0;
  int          n_fail   = 0;

  mext_if md_bus ();

  mext_ctrl #(.BYPASS_SPECIAL(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .kill      (kill),
    .stall     (stall),
    .res_valid (res_valid),
    .res       (res),
    .md        (md_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          n_stall;
    int          n_md;
    logic [31:0] a;
    logic [31:0] b;
    bit          done;
  } obs_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          byp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Result of an RV32M op computed directly from the ISA rules with wide arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    p  = '0;
    q  = 0;
    case (f)
      3'd0, 3'd1: p = 64'(sa * sb);
      3'd2:       p = 64'(sa * ub);
      3'd3:       p = {32'd0, a} * {32'd0, b};
      default:    ;
    endcase
    case (f)
      3'd0:             return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && b == 0) ||
           ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Behavioural core: answers 32 cycles after the launch pulse.
  initial begin : core_model
    logic [31:0] ca, cb;
    logic        cmode;
    md_bus.md_ready = 1'b0;
    md_bus.md_out   = '0;
    forever begin
      @(posedge clk);
      if (md_bus.md_valid === 1'b1) begin
        ca    = md_bus.md_a;
        cb    = md_bus.md_b;
        cmode = md_bus.md_mode;
        repeat (CORE_WAIT) @(posedge clk);
        #1;
        md_bus.md_ready = 1'b1;
        if (!cmode)       md_bus.md_out = 64'(ca) * 64'(cb);
        else if (cb == 0) md_bus.md_out = {ca, 32'hFFFF_FFFF};
        else              md_bus.md_out = {ca % cb, ca / cb};
        @(posedge clk);
        #1;
        md_bus.md_ready = 1'b0;
      end
    end
  end

  // Presents one instruction (called 1 time unit after a rising edge) and holds it
  // until the result pulse; returns one time unit after the following rising edge.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output obs_t o);
    o.res = '0; o.lat = -1; o.n_stall = 0; o.n_md = 0; o.a = '0; o.b = '0; o.done = 1'b0;
    req_valid = 1'b1;
    funct3    = f;
    rs1       = a;
    rs2       = b;
    for (int cyc = 0; cyc < BUDGET && !o.done; cyc++) begin
      @(negedge clk);
      if (stall) o.n_stall++;
      if (md_bus.md_valid) begin
        o.n_md++;
        o.a = md_bus.md_a;
        o.b = md_bus.md_b;
      end
      if (res_valid) begin
        o.res  = res;
        o.lat  = cyc;
        o.done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic check_op(input string tag, input obs_t o, input logic [31:0] exp_res,
                          input bit byp);
    check({tag, "_done"}, 64'(o.done), 64'd1);
    check({tag, "_res"}, 64'(o.res), 64'(exp_res));
    check({tag, "_lat"}, 64'(o.lat), 64'(byp ? LAT_BYP : LAT_CORE));
    check({tag, "_stall_cycles"}, 64'(o.n_stall), 64'(byp ? LAT_BYP : LAT_CORE));
    check({tag, "_md_valid_pulses"}, 64'(o.n_md), byp ? 64'd0 : 64'd1);
  endtask

  vec_t        vecs[$];
  obs_t        obs;
  logic [2:0]  rf;
  logic [31:0] ra, rb;
  bit          saw_res, ready_seen, released, rel_after_ready;

  initial begin
    vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0});
    vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0});
    vecs.push_back('{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{OP_REMU,   32'd5,         32'd0,         32'd5,         1'b1});
    vecs.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vecs.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1});
    vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b1});
    vecs.push_back('{OP_DIVU,   32'd100,       32'd7,         32'd14,        1'b0});
    vecs.push_back('{OP_REMU,   32'd100,       32'd7,         32'd2,         1'b0});
    vecs.push_back('{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0});

    rst_n = 1'b0; req_valid = 1'b0; kill = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_md_valid", 64'(md_bus.md_valid), 64'd0);
    check("reset_res", 64'(res), 64'd0);
    check("reset_md_ab", {md_bus.md_a, md_bus.md_b}, 64'd0);
    check("reset_md_mode", 64'(md_bus.md_mode), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Signed MUL through the core: magnitudes handed over and exact stall length.
    do_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, obs);
    check_op("mul_neg", obs, 32'hFFFF_FFEB, 1'b0);
    check("mul_neg_md_a", 64'(obs.a), 64'd7);
    check("mul_neg_md_b", 64'(obs.b), 64'd3);
    @(negedge clk);
    check("res_valid_single_pulse", 64'(res_valid), 64'd0);
    @(posedge clk);
    #1;

    // Table vectors, issued back to back.
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, obs);
      check_op($sformatf("vec%0d", i), obs, vecs[i].exp, vecs[i].byp);
    end

    // kill in IDLE blocks acceptance.
    req_valid = 1'b1; kill = 1'b1; funct3 = OP_DIVU; rs1 = 32'd5; rs2 = 32'd0;
    saw_res = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (stall || md_bus.md_valid || res_valid) saw_res = 1'b1;
    end
    check("kill_idle_no_activity", 64'(saw_res), 64'd0);
    check("kill_idle_state", 64'(dut.state), 64'(ST_IDLE));
    @(posedge clk);
    #1;
    req_valid = 1'b0; kill = 1'b0;

    // kill in DONE suppresses the result pulse.
    req_valid = 1'b1; funct3 = OP_DIVU; rs1 = 32'd5; rs2 = 32'd0;
    @(posedge clk);
    #1;
    kill = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("kill_done_state", 64'(dut.state), 64'(ST_DONE));
    check("kill_done_res_valid", 64'(res_valid), 64'd0);
    @(posedge clk);
    #1;
    kill = 1'b0;
    @(negedge clk);
    check("kill_done_no_late_res", 64'(res_valid), 64'd0);
    @(posedge clk);
    #1;

    // kill ten cycles into a core operation: drain until the core answers.
    req_valid = 1'b1; funct3 = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy_state", 64'(dut.state), 64'(ST_DRAIN));
    saw_res = 1'b0; ready_seen = 1'b0; released = 1'b0; rel_after_ready = 1'b0;
    for (int c = 0; c < BUDGET && !released; c++) begin
      @(negedge clk);
      if (res_valid) saw_res = 1'b1;
      if (!stall) begin
        released        = 1'b1;
        rel_after_ready = ready_seen;
      end
      if (md_bus.md_ready) ready_seen = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      if (res_valid) saw_res = 1'b1;
    end
    check("kill_busy_released", 64'(released), 64'd1);
    check("kill_busy_release_after_ready", 64'(rel_after_ready), 64'd1);
    check("kill_busy_no_res_valid", 64'(saw_res), 64'd0);
    @(posedge clk);
    #1;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, obs);
    check_op("after_kill", obs, 32'hFFFF_FFFD, 1'b0);

    // Reset in the middle of a core operation, pipeline still presenting the request.
    req_valid = 1'b1; funct3 = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy_stall", 64'(stall), 64'd0);
    check("rst_busy_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy_md_valid", 64'(md_bus.md_valid), 64'd0);
    check("rst_busy_res", 64'(res), 64'd0);
    check("rst_busy_md_ab", {md_bus.md_a, md_bus.md_b}, 64'd0);
    check("rst_busy_md_mode", 64'(md_bus.md_mode), 64'd0);
    check("rst_busy_state", 64'(dut.state), 64'(ST_IDLE));
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_res = 1'b0; ready_seen = 1'b0;
    for (int c = 0; c < BUDGET && !ready_seen; c++) begin
      @(negedge clk);
      if (res_valid) saw_res = 1'b1;
      if (md_bus.md_ready) ready_seen = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      if (res_valid) saw_res = 1'b1;
    end
    check("rst_late_ready_arrived", 64'(ready_seen), 64'd1);
    check("rst_late_ready_no_res", 64'(saw_res), 64'd0);
    check("rst_late_ready_state", 64'(dut.state), 64'(ST_IDLE));
    @(posedge clk);
    #1;
    do_op(OP_REMU, 32'd100, 32'd7, obs);
    check_op("after_reset", obs, 32'd2, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      do_op(rf, ra, rb, obs);
      check_op($sformatf("rnd%0d_f%0d_%08h_%08h", i, rf, ra, rb), obs,
               ref_model(rf, ra, rb), is_special(rf, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
